// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decoder constants: zigzag map, dequant/zigzag FSM states, datapath widths.
package jpeg_dec_pkg;

  localparam int COEF_W = 12;
  localparam int Q_W    = 8;
  localparam int PIX_W  = 8;

  // ZZ_TO_NAT[k] is the raster (row*8+col) index of zigzag position k.
  localparam logic [5:0] ZZ_TO_NAT [0:63] = '{
     6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    EMIT    = 2'd2
  } dqz_state_t;

endpackage

// File: rtl/jpeg_dequant_zigzag_if.sv
// Bus bundle for the dequant/zigzag stage: table writes, coefficient stream, block output.
interface jpeg_dequant_zigzag_if;
  import jpeg_dec_pkg::*;

  logic                     qt_wr_en;
  logic [5:0]               qt_wr_addr;
  logic [Q_W-1:0]           qt_wr_data;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [COEF_W-1:0] s_coef;
  logic [5:0]               s_zz;
  logic                     s_eob;
  logic [64*PIX_W-1:0]      data_out;
  logic                     m_valid;

  modport slave (
    input  qt_wr_en, qt_wr_addr, qt_wr_data, s_valid, s_coef, s_zz, s_eob,
    output s_ready, data_out, m_valid
  );

  modport master (
    output qt_wr_en, qt_wr_addr, qt_wr_data, s_valid, s_coef, s_zz, s_eob,
    input  s_ready, data_out, m_valid
  );

endinterface

// File: rtl/dequant_mul.sv
// Registered signed coefficient x unsigned quantizer, arithmetic shift, saturate to PIX_W.
module dequant_mul
  import jpeg_dec_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [COEF_W-1:0] coef,
  input  logic [Q_W-1:0]           q,
  output logic signed [PIX_W-1:0]  pix
);

  localparam int PROD_W = COEF_W + Q_W + 1;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (PIX_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [PIX_W-1:0]  pix_c;

  // zero-extend q by one bit so it multiplies as a non-negative signed operand
  assign prod    = PROD_W'(coef) * PROD_W'($signed({1'b0, q}));
  assign shifted = prod >>> SHIFT;

  always_comb begin
    pix_c = shifted[PIX_W-1:0];
    if (shifted > SAT_MAX)
      pix_c = SAT_MAX[PIX_W-1:0];
    else if (shifted < SAT_MIN)
      pix_c = SAT_MIN[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      pix <= '0;
    else
      pix <= pix_c;
  end

endmodule

// File: rtl/jpeg_dequant_zigzag.sv
// Dequantize zigzag-ordered coefficients into a natural-order 8x8 bank and emit rate-limited blocks.
//   state   | meaning
//   COLLECT | accepting coefficients into the bank
//   FLUSH   | last pipelined product lands in the bank
//   EMIT    | waiting for gap counter to expire, then publish block
module jpeg_dequant_zigzag
  import jpeg_dec_pkg::*;
#(
  parameter int MIN_GAP = 40,
  parameter int SHIFT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  jpeg_dequant_zigzag_if.slave bus
);

  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;

  dqz_state_t          state, state_nxt;
  logic [Q_W-1:0]      qt [0:63];
  logic [PIX_W-1:0]    bank [0:63];
  logic [GAP_W-1:0]    gap_cnt;
  logic [5:0]          wr_idx;
  logic                wr_vld;
  logic signed [PIX_W-1:0] wr_pix;
  logic [64*PIX_W-1:0] data_q;
  logic                m_valid_q;
  logic                ready_c;
  logic                emit;
  logic                accept;
  logic                blk_end;

  assign accept  = bus.s_valid & ready_c;
  assign blk_end = accept & (bus.s_eob | (bus.s_zz == 6'd63));

  assign bus.s_ready  = ready_c;
  assign bus.data_out = data_q;
  assign bus.m_valid  = m_valid_q;

  // table read is combinational, so a same-edge write is seen only by later beats
  dequant_mul #(.SHIFT(SHIFT)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .coef (bus.s_coef),
    .q    (qt[bus.s_zz]),
    .pix  (wr_pix)
  );

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    emit      = 1'b0;
    case (state)
      COLLECT: begin
        ready_c = 1'b1;
        if (blk_end) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = EMIT;
      EMIT: begin
        if (gap_cnt == '0) begin
          emit      = 1'b1;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      gap_cnt   <= '0;
      wr_vld    <= 1'b0;
      wr_idx    <= '0;
      data_q    <= '0;
      m_valid_q <= 1'b0;
      for (int n = 0; n < 64; n++) begin
        qt[n]   <= Q_W'(1);
        bank[n] <= '0;
      end
    end else begin
      state     <= state_nxt;
      wr_vld    <= accept;
      wr_idx    <= ZZ_TO_NAT[bus.s_zz];
      m_valid_q <= emit;
      if (bus.qt_wr_en) qt[bus.qt_wr_addr] <= bus.qt_wr_data;
      if (wr_vld) bank[wr_idx] <= wr_pix;
      if (emit) begin
        gap_cnt <= GAP_W'(MIN_GAP - 1);
        for (int n = 0; n < 64; n++) begin
          data_q[8*n +: 8] <= bank[n];
          bank[n]          <= '0;
        end
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_dequant_zigzag.sv
// Directed bench for jpeg_dequant_zigzag: reset, DC, zigzag map, saturation, gap, mid-block reset.
module tb_jpeg_dequant_zigzag;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jpeg_dequant_zigzag_if bus ();

  jpeg_dequant_zigzag #(.MIN_GAP(40), .SHIFT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // raster index -> zigzag index (standard JPEG table layout, row by row)
  int nat_to_zz [0:63] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_coef = '0;
    bus.s_zz = '0;
    bus.s_eob = 1'b0;
    bus.qt_wr_en = 1'b0;
    bus.qt_wr_addr = '0;
    bus.qt_wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic qt_write(input logic [5:0] addr, input logic [7:0] val);
    bus.qt_wr_en = 1'b1;
    bus.qt_wr_addr = addr;
    bus.qt_wr_data = val;
    @(posedge clk);
    #1 bus.qt_wr_en = 1'b0;
  endtask

  task automatic send_beat(input logic signed [11:0] coef, input logic [5:0] zz, input logic eob);
    int n = 0;
    while (!bus.s_ready && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    bus.s_valid = 1'b1;
    bus.s_coef = coef;
    bus.s_zz = zz;
    bus.s_eob = eob;
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
    bus.s_eob = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output bit found, output int cycles, output int ready_hi);
    found = 1'b0;
    cycles = 0;
    ready_hi = 0;
    while (!found && cycles < budget) begin
      @(posedge clk);
      #1 cycles++;
      if (bus.m_valid) found = 1'b1;
      else if (bus.s_ready) ready_hi++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.data_out !== '0) begin
      failures++;
      $display("FAIL reset_data_out got=%h want=0", bus.data_out);
    end
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_m_valid got=%b want=0", bus.m_valid);
    end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_s_ready got=%b want=1", bus.s_ready);
    end
  endtask

  task automatic test_dc();
    bit found;
    int cycles, rh;
    logic [511:0] exp_d;
    do_reset();
    send_beat(12'sd5, 6'd0, 1'b1);
    wait_pulse(100, found, cycles, rh);
    exp_d = '0;
    exp_d[7:0] = 8'h05;
    checks++;
    if (!found || cycles != 2) begin
      failures++;
      $display("FAIL dc_latency got=%0d found=%0b want=2", cycles, found);
    end
    checks++;
    if (bus.data_out !== exp_d) begin
      failures++;
      $display("FAIL dc_data got=%h want=%h", bus.data_out, exp_d);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.data_out !== exp_d) begin
      failures++;
      $display("FAIL dc_pulse_hold m_valid=%b data=%h want m_valid=0 data held", bus.m_valid, bus.data_out);
    end
  endtask

  task automatic test_zigzag();
    bit found;
    int cycles, rh;
    logic [511:0] exp_d;
    do_reset();
    for (int k = 0; k < 64; k++) send_beat(12'(k), 6'(k), 1'b0);
    wait_pulse(100, found, cycles, rh);
    for (int n = 0; n < 64; n++) exp_d[8*n +: 8] = 8'(nat_to_zz[n]);
    checks++;
    if (!found || cycles != 2) begin
      failures++;
      $display("FAIL zz_latency got=%0d found=%0b want=2", cycles, found);
    end
    checks++;
    if (bus.data_out !== exp_d) begin
      failures++;
      $display("FAIL zz_data got=%h want=%h", bus.data_out, exp_d);
    end
    checks++;
    if (bus.data_out[71:64] !== 8'd2 || bus.data_out[511:504] !== 8'd63) begin
      failures++;
      $display("FAIL zz_bytes b8=%0d b63=%0d want 2 63", bus.data_out[71:64], bus.data_out[511:504]);
    end
  endtask

  task automatic test_saturation();
    bit found;
    int cycles, rh;
    logic [511:0] exp_d;
    do_reset();
    qt_write(6'd0, 8'd16);
    qt_write(6'd1, 8'd16);
    qt_write(6'd2, 8'd3);
    send_beat(12'sd100, 6'd0, 1'b0);
    send_beat(-12'sd100, 6'd1, 1'b0);
    send_beat(-12'sd7, 6'd2, 1'b1);
    wait_pulse(100, found, cycles, rh);
    exp_d = '0;
    exp_d[7:0] = 8'h7F;
    exp_d[15:8] = 8'h80;
    exp_d[71:64] = 8'hEB;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL sat_pulse got=none want=pulse");
    end
    checks++;
    if (bus.data_out[7:0] !== 8'h7F) begin
      failures++;
      $display("FAIL sat_pos got=%h want=7f", bus.data_out[7:0]);
    end
    checks++;
    if (bus.data_out[15:8] !== 8'h80) begin
      failures++;
      $display("FAIL sat_neg got=%h want=80", bus.data_out[15:8]);
    end
    checks++;
    if (bus.data_out[71:64] !== 8'hEB) begin
      failures++;
      $display("FAIL sat_inrange got=%h want=eb", bus.data_out[71:64]);
    end
    checks++;
    if (bus.data_out !== exp_d) begin
      failures++;
      $display("FAIL sat_block got=%h want=%h", bus.data_out, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    int cycles, rh, t1, t2;
    logic [511:0] exp_d;
    do_reset();
    send_beat(12'sd3, 6'd0, 1'b1);
    wait_pulse(100, found, cycles, rh);
    t1 = cyc;
    send_beat(12'sd7, 6'd1, 1'b1);
    wait_pulse(200, found, cycles, rh);
    t2 = cyc;
    exp_d = '0;
    exp_d[15:8] = 8'd7;
    checks++;
    if (!found || (t2 - t1) != 40) begin
      failures++;
      $display("FAIL gap_spacing got=%0d found=%0b want=40", t2 - t1, found);
    end
    checks++;
    if (rh != 0) begin
      failures++;
      $display("FAIL gap_ready_low got=%0d high cycles want=0", rh);
    end
    checks++;
    if (bus.data_out !== exp_d) begin
      failures++;
      $display("FAIL gap_data got=%h want=%h", bus.data_out, exp_d);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL gap_single_pulse got=%b want=0", bus.m_valid);
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    int cycles, rh, pulses;
    logic [511:0] exp_d;
    do_reset();
    for (int k = 0; k < 10; k++) send_beat(12'sd9, 6'(k), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (bus.m_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL mid_reset_no_pulse got=%0d want=0", pulses);
    end
    checks++;
    if (bus.s_ready !== 1'b1 || bus.data_out !== '0) begin
      failures++;
      $display("FAIL mid_reset_state ready=%b data=%h want ready=1 data=0", bus.s_ready, bus.data_out);
    end
    send_beat(12'sd4, 6'd5, 1'b1);
    wait_pulse(100, found, cycles, rh);
    exp_d = '0;
    exp_d[23:16] = 8'd4;
    checks++;
    if (!found || cycles != 2) begin
      failures++;
      $display("FAIL mid_reset_latency got=%0d found=%0b want=2", cycles, found);
    end
    checks++;
    if (bus.data_out !== exp_d) begin
      failures++;
      $display("FAIL mid_reset_data got=%h want=%h", bus.data_out, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_zigzag();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
